fir_mac_sequencer: RTL and testbench
====================================

// Module: fir_mac_sequencer
// PURPOSE
//   Time-multiplexed NTAPS-tap FIR engine with a single shared 16x16 multiplier.
//   A controller FSM accepts one sample and steps the MAC through the taps.
//   It then scales and saturates the result and presents it on a ready/valid output.
//   Coefficients are double-buffered so that host writes never disturb a sample in flight.
//   The block sits between the sample source and the downstream consumer in the filter chain.
// PARAMETERS
//   NTAPS  4   number of taps; also the number of MAC cycles per sample
//   DW     16  sample width, signed; also the output width
//   CW     16  coefficient width, signed
//   SHIFT  16  arithmetic right shift applied to the accumulator before saturation
// PORTS
//   i_clk         in   1       clock
//   i_rstb        in   1       reset, asynchronous, active-low
//   i_in_valid    in   1       input sample valid
//   o_in_ready    out  1       block can accept a sample
//   i_in_data     in   DW      signed input sample
//   o_out_valid   out  1       filtered output valid
//   i_out_ready   in   1       downstream accepts the output
//   o_out_data    out  DW      signed, saturated filter output
//   i_coef_we     in   1       coefficient shadow write strobe
//   i_coef_addr   in   clog2(NTAPS)  tap index to write
//   i_coef_wdata  in   CW      signed coefficient value
//   o_busy        out  1       state != IDLE
// BEHAVIOUR
//   Reset (async, i_rstb=0): state=IDLE; delay line, shadow and active coefs, accumulator, tap counter all 0.
//     Output values during and after reset: o_out_valid=0, o_out_data=0, o_busy=0, o_in_ready=1.
//   FSM states:
//     IDLE: o_in_ready=1.
//       On the accept edge (i_in_valid & o_in_ready):
//         dl[0]<=i_in_data, dl[k]<=dl[k-1];
//         active coefs <= shadow coefs (pre-edge values);
//         acc<=0, tap<=0; go MAC.
//     MAC: each edge acc <= acc + dl[tap]*coef[tap], tap++.
//       At tap==NTAPS-1: o_out_data <= sat(acc + last product); go OUT.
//     OUT: o_out_valid=1; o_out_data held stable.
//       On i_out_ready: go IDLE; o_out_valid drops the next cycle.
//   Latency: o_out_valid is high NTAPS+1 edges after the accept edge.
//   Throughput: minimum sample period NTAPS+2 cycles (NTAPS=4 -> 6).
//   Arithmetic:
//     product is CW+DW bits signed; acc is CW+DW+clog2(NTAPS) bits signed (34 at defaults).
//     r = acc >>> SHIFT.
//     If r > 2^(DW-1)-1 -> 0x7FFF; if r < -2^(DW-1) -> 0x8000; else r[DW-1:0].
//   Coefficient writes:
//     Accepted in any state; they land in the shadow bank only.
//     A write on the accept edge takes effect for the NEXT sample.
//     Two writes to the same address: the last write wins.
//   Backpressure: in OUT with i_out_ready=0, the block holds indefinitely; o_in_ready=0, no input accepted.
//   i_in_valid outside IDLE is ignored; the source must hold data until ready.
//   Reset mid-operation: aborts immediately to the reset values; the in-flight sample is lost.
// CONFIGURATION
//   FIR_SEQ_ROUND_EN defined: r = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round half up before saturation.
//   FIR_SEQ_ROUND_EN undefined: truncation, floor toward -inf.
// STRUCTURE
//   fir_seq_pkg holds:
//     state enum {IDLE, MAC, OUT};
//     localparams ACCW=CW+DW+$clog2(NTAPS) and TAPW=$clog2(NTAPS);
//     function sat_scale().
//   One sub-module, fir_sat_scale: combinational shift, optional round and saturate, instantiated once.
// TESTING
//   Impulse: coefs {0x4000,0x2000,0x1000,0x0800}, samples 0x7FFF,0,0,0,0.
//     Truncating outputs: 8191, 4095, 2047, 1023, 0.
//     With FIR_SEQ_ROUND_EN the first output is 8192.
//   Positive saturation: all coefs 0x7FFF, four samples 0x7FFF.
//     4th output = 0x7FFF (raw 65532).
//   Negative saturation: all coefs 0x7FFF, four samples 0x8000.
//     4th output = 0x8000 (raw -65534).
//   Backpressure: i_out_ready=0 for 10 cycles in OUT.
//     o_out_valid=1 and o_out_data stable; o_in_ready=0; no sample taken.
//   Coef update in flight: write coef0=0 during MAC of a 0x7FFF impulse.
//     Current output = 8191; the next sample 0x7FFF yields 0 + dl[1] contribution (4095).
//   Reset mid-MAC: pulse i_rstb low.
//     o_out_valid=0, o_busy=0, o_in_ready=1; a following impulse with zero coefs gives 0.
//   Back-to-back: i_in_valid=1 and i_out_ready=1 constantly.
//     Exactly one accept every 6 cycles; o_out_valid rises 5 edges after each accept.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// Shared types, sizes and the scale/saturate helper for the FIR MAC sequencer.
// Rounding is selected by FIR_SEQ_ROUND_EN (undefined: truncate toward -inf).
package fir_seq_pkg;

    localparam int NTAPS = 4;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int SHIFT = 16;
    localparam int TAPW  = $clog2(NTAPS);
    localparam int PW    = CW + DW;
    localparam int ACCW  = PW + TAPW;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    localparam logic signed [ACCW-1:0] SMAX =
        {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SMIN =
        {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`ifdef FIR_SEQ_ROUND_EN
    localparam logic signed [ACCW-1:0] HALF =
        {{(ACCW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
`endif

    function automatic logic signed [DW-1:0] sat_scale(
        input logic signed [ACCW-1:0] acc
    );
        logic signed [ACCW-1:0] r;
`ifdef FIR_SEQ_ROUND_EN
        r = (acc + HALF) >>> SHIFT;
`else
        r = acc >>> SHIFT;
`endif
        if (r > SMAX)
            return SMAX[DW-1:0];
        else if (r < SMIN)
            return SMIN[DW-1:0];
        else
            return r[DW-1:0];
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_sat_scale.sv
// Combinational accumulator scaling: arithmetic shift, optional round, saturate.
// Rounding behaviour follows FIR_SEQ_ROUND_EN through fir_seq_pkg::sat_scale.
module fir_sat_scale
    import fir_seq_pkg::*;
(
    input  logic signed [ACCW-1:0] acc,
    output logic signed [DW-1:0]   res
);

    assign res = sat_scale(acc);

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR with one shared multiplier and double-buffered coefficients.
// Build option FIR_SEQ_ROUND_EN selects round-half-up scaling instead of truncation.
module fir_mac_sequencer
    import fir_seq_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rstb,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic signed [DW-1:0] i_in_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic signed [DW-1:0] o_out_data,
    input  logic                 i_coef_we,
    input  logic [TAPW-1:0]      i_coef_addr,
    input  logic signed [CW-1:0] i_coef_wdata,
    output logic                 o_busy
);

    state_t state, state_nx;

    logic signed [DW-1:0]   dl     [NTAPS];
    logic signed [CW-1:0]   shadow [NTAPS];
    logic signed [CW-1:0]   coef   [NTAPS];
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] prod_x;
    logic signed [PW-1:0]   prod;
    logic signed [DW-1:0]   scaled;
    logic signed [DW-1:0]   out_data;
    logic [TAPW-1:0]        tap;
    logic                   accept;
    logic                   last;

    assign accept = i_in_valid && (state == IDLE);
    assign last   = (tap == TAPW'(NTAPS - 1));

    assign prod   = PW'(dl[tap]) * PW'(coef[tap]);
    assign prod_x = {{TAPW{prod[PW-1]}}, prod};
    assign sum    = acc + prod_x;

    fir_sat_scale u_sat (
        .acc (sum),
        .res (scaled)
    );

    always_comb begin
        state_nx    = state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b1;
        unique case (state)
            IDLE: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b0;
                if (accept)
                    state_nx = MAC;
            end
            MAC: begin
                if (last)
                    state_nx = OUT;
            end
            OUT: begin
                o_out_valid = 1'b1;
                if (i_out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Host writes only touch the shadow bank; the active bank is snapped on accept.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            for (int k = 0; k < NTAPS; k++)
                shadow[k] <= '0;
        end else if (i_coef_we) begin
            shadow[i_coef_addr] <= i_coef_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            for (int k = 0; k < NTAPS; k++) begin
                dl[k]   <= '0;
                coef[k] <= '0;
            end
            acc      <= '0;
            tap      <= '0;
            out_data <= '0;
        end else if (accept) begin
            dl[0] <= i_in_data;
            for (int k = 1; k < NTAPS; k++)
                dl[k] <= dl[k-1];
            for (int k = 0; k < NTAPS; k++)
                coef[k] <= shadow[k];
            acc <= '0;
            tap <= '0;
        end else if (state == MAC) begin
            acc <= sum;
            tap <= tap + 1'b1;
            if (last)
                out_data <= scaled;
        end
    end

    assign o_out_data = out_data;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed self-checking bench for fir_mac_sequencer.
// Expected values are hand-computed; FIR_SEQ_ROUND_EN selects the rounded set.
module tb_fir_mac_sequencer;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_addr = '0;
    logic [15:0] coef_wdata = '0;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FIR_SEQ_ROUND_EN
    int exp_imp [5] = '{8192, 4096, 2048, 1024, 0};
`else
    int exp_imp [5] = '{8191, 4095, 2047, 1023, 0};
`endif

    always #5 clk = ~clk;

    fir_mac_sequencer dut (
        .i_clk        (clk),
        .i_rstb       (rstb),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .i_coef_we    (coef_we),
        .i_coef_addr  (coef_addr),
        .i_coef_wdata (coef_wdata),
        .o_busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        coef_we   = 1'b0;
        rstb      = 1'b0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic wr_coef(input int a, input logic [15:0] d);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 2'(a);
        coef_wdata = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic load_impulse_coefs();
        wr_coef(0, 16'h4000);
        wr_coef(1, 16'h2000);
        wr_coef(2, 16'h1000);
        wr_coef(3, 16'h0800);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20)
            check("out_timeout", 1, 0);
    endtask

    // Send one sample, optionally stall the output for 'hold' cycles.
    task automatic run_sample(input logic [15:0] s, input int hold,
                              output logic [15:0] y, output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = s;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20)
            check("accept_timeout", 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        y = out_data;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1234;
            check("bp_valid", 32'(out_valid), 1);
            check("bp_stable", 32'(out_data), 32'(y));
            check("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] y;
        int lat;
        int acc_t[$];
        int rise_t[$];
        logic prev;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rstb = 1'b1;

        // impulse response
        load_impulse_coefs();
        run_sample(16'h7FFF, 0, y, lat);
        check("imp0", 32'(y), 32'(exp_imp[0]));
        check("latency", 32'(lat), 4);
        for (int i = 1; i < 5; i++) begin
            run_sample(16'h0000, 0, y, lat);
            check($sformatf("imp%0d", i), 32'(y), 32'(exp_imp[i]));
        end

        // positive saturation
        do_reset();
        for (int i = 0; i < 4; i++)
            wr_coef(i, 16'h7FFF);
        for (int i = 0; i < 4; i++)
            run_sample(16'h7FFF, 0, y, lat);
        check("sat_pos", 32'(y), 32'h7FFF);

        // negative saturation; coef0 written twice, last write wins
        do_reset();
        wr_coef(0, 16'h1234);
        for (int i = 0; i < 4; i++)
            wr_coef(i, 16'h7FFF);
        for (int i = 0; i < 4; i++)
            run_sample(16'h8000, 0, y, lat);
        check("sat_neg", 32'(y), 32'h8000);

        // backpressure: hold 10 cycles while a stray sample is offered
        do_reset();
        load_impulse_coefs();
        run_sample(16'h7FFF, 10, y, lat);
        check("bp_out", 32'(y), 32'(exp_imp[0]));
        run_sample(16'h0000, 0, y, lat);
        check("bp_no_take", 32'(y), 32'(exp_imp[1]));

        // coefficient write while a sample is in flight
        do_reset();
        load_impulse_coefs();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        @(negedge clk);
        in_valid   = 1'b0;
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 16'h0000;
        @(negedge clk);
        coef_we = 1'b0;
        wait_out(lat);
        check("flight_cur", 32'(out_data), 32'(exp_imp[0]));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        run_sample(16'h7FFF, 0, y, lat);
        check("flight_next", 32'(y), 32'(exp_imp[1]));

        // asynchronous reset in the middle of MAC
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        #1 rstb = 1'b0;
        #2;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(in_ready), 1);
        @(negedge clk);
        rstb = 1'b1;
        run_sample(16'h7FFF, 0, y, lat);
        check("mid_rst_zero", 32'(y), 0);

        // back-to-back streaming
        do_reset();
        load_impulse_coefs();
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 16'h0100;
        out_ready = 1'b1;
        prev      = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (in_valid && in_ready)
                acc_t.push_back(cyc);
            if (out_valid && !prev)
                rise_t.push_back(cyc);
            prev = out_valid;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_accepts", 32'(acc_t.size()), 10);
        for (int i = 1; i < acc_t.size(); i++)
            check("b2b_period", 32'(acc_t[i] - acc_t[i-1]), 6);
        check("b2b_rises", 32'(rise_t.size()), 10);
        for (int i = 0; i < rise_t.size() && i < acc_t.size(); i++)
            check("b2b_latency", 32'(rise_t[i] - acc_t[i]), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
